// File: rtl/reset_seq_if.sv
// Host-side view of reset_seq: soft-reset request/acknowledge handshake
// plus the sequenced resets and status flags it drives.
interface reset_seq_if #(
  parameter int NR_OUTPUTS = 4
);
  logic                  soft_reset_req;
  logic                  soft_reset_ack;
  logic [NR_OUTPUTS-1:0] reset_out_;
  logic                  seq_done;
  logic                  lock_timeout;

  modport master (
    output soft_reset_req,
    input  soft_reset_ack,
    input  reset_out_,
    input  seq_done,
    input  lock_timeout
  );

  modport slave (
    input  soft_reset_req,
    output soft_reset_ack,
    output reset_out_,
    output seq_done,
    output lock_timeout
  );
endinterface

// File: rtl/reset_seq.sv
// Board reset sequencer: synchronizes reset_in_ and pll_lock into clk and releases reset_out_ bits in order.
// Build option RESET_SEQ_WATCHDOG_EN adds a sticky PLL-lock timeout flag (lock_timeout tied low otherwise).
//
// state     | meaning
// WAIT_LOCK | all resets asserted, waiting for synchronized PLL lock
// RELEASE   | releasing reset_out_ one bit every DELAY_CYCLES, bit 0 first
// RUN       | all resets released, soft-reset requests accepted
// HOLD      | soft reset: all resets asserted for DELAY_CYCLES
module reset_seq #(
  parameter int NR_OUTPUTS   = 4,
  parameter int DELAY_CYCLES = 16,
  parameter int CNTR_W       = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset_in_,
  input  logic       pll_lock,
  reset_seq_if.slave sif
);

  localparam int IDX_W = (NR_OUTPUTS > 1) ? $clog2(NR_OUTPUTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NR_OUTPUTS - 1);
  localparam logic [CNTR_W-1:0] DLY_LAST = CNTR_W'(DELAY_CYCLES - 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] RELEASE   = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] HOLD      = 2'd3;

  if (NR_OUTPUTS < 1 || NR_OUTPUTS > 8 || DELAY_CYCLES < 1 ||
      (1 << CNTR_W) <= DELAY_CYCLES || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("reset_seq: illegal parameter combination");
  end

  logic [1:0] rst_sync_q, rst_sync_d;
  logic [1:0] lock_sync_q, lock_sync_d;
  logic       rst_n;
  logic       lock_s;

  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    lock_sync_d = {lock_sync_q[0], pll_lock};
  end

  // Both synchronizers clear straight from the board reset so a short glitch
  // on reset_in_ also forgets any previously seen lock.
  always_ff @(posedge clk or negedge reset_in_) begin
    if (!reset_in_) begin
      rst_sync_q  <= '0;
      lock_sync_q <= '0;
    end else begin
      rst_sync_q  <= rst_sync_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign rst_n  = rst_sync_q[1];
  assign lock_s = lock_sync_q[1];

  logic [1:0]            state_q, state_d;
  logic [CNTR_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NR_OUTPUTS-1:0] reset_out_q, reset_out_d;
  logic                  seq_done_q, seq_done_d;
  logic                  soft_reset_ack_q, soft_reset_ack_d;
  logic                  ack_pending_q, ack_pending_d;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    idx_d            = idx_q;
    reset_out_d      = reset_out_q;
    seq_done_d       = seq_done_q;
    soft_reset_ack_d = 1'b0;
    ack_pending_d    = ack_pending_q;

    // Lock loss wins over everything; ack_pending survives so a pending soft
    // sequence still gets its ack once RUN is reached again.
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d     = WAIT_LOCK;
      cnt_d       = '0;
      idx_d       = '0;
      reset_out_d = '0;
      seq_done_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          reset_out_d = '0;
          seq_done_d  = 1'b0;
          if (lock_s) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (cnt_q == DLY_LAST) begin
            cnt_d       = '0;
            // Shift in a one so bits can only release in index order.
            reset_out_d = NR_OUTPUTS'({reset_out_q, 1'b1});
            if (idx_q == LAST_IDX) begin
              state_d          = RUN;
              seq_done_d       = 1'b1;
              soft_reset_ack_d = ack_pending_q;
              ack_pending_d    = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNTR_W'(1);
          end
        end
        RUN: begin
          if (sif.soft_reset_req && !soft_reset_ack_q) begin
            state_d       = HOLD;
            cnt_d         = '0;
            reset_out_d   = '0;
            seq_done_d    = 1'b0;
            ack_pending_d = 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == DLY_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q + CNTR_W'(1);
          end
        end
        default: begin
          state_d     = WAIT_LOCK;
          reset_out_d = '0;
          seq_done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      idx_q            <= '0;
      reset_out_q      <= '0;
      seq_done_q       <= 1'b0;
      soft_reset_ack_q <= 1'b0;
      ack_pending_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      reset_out_q      <= reset_out_d;
      seq_done_q       <= seq_done_d;
      soft_reset_ack_q <= soft_reset_ack_d;
      ack_pending_q    <= ack_pending_d;
    end
  end

  assign sif.reset_out_     = reset_out_q;
  assign sif.seq_done       = seq_done_q;
  assign sif.soft_reset_ack = soft_reset_ack_q;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOCK_TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            lock_timeout_q, lock_timeout_d;

  always_comb begin
    wd_cnt_d       = '0;
    lock_timeout_d = lock_timeout_q;
    if (state_q == WAIT_LOCK) begin
      if (wd_cnt_q == WD_LAST) begin
        wd_cnt_d       = wd_cnt_q;
        lock_timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q       <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      wd_cnt_q       <= wd_cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign sif.lock_timeout = lock_timeout_q;
`else
  assign sif.lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq (3 outputs, 4-cycle spacing): expected output changes are queued
// with the edge number they must appear on, and a negedge monitor pops and compares every change.
module tb_reset_seq;
  localparam int NR  = 3;
  localparam int DLY = 4;
  localparam int LT  = 32;
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic WD_EXP = 1'b1;
`else
  localparam logic WD_EXP = 1'b0;
`endif

  logic clk       = 1'b0;
  logic reset_in_ = 1'b1;
  logic pll_lock  = 1'b1;
  int   cyc       = 0;
  int   total     = 0;
  int   bad       = 0;

  reset_seq_if #(.NR_OUTPUTS(NR)) sif ();

  reset_seq #(
    .NR_OUTPUTS  (NR),
    .DELAY_CYCLES(DLY),
    .CNTR_W      (8),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk      (clk),
    .reset_in_(reset_in_),
    .pll_lock (pll_lock),
    .sif      (sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t expq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] ro, input logic sd, input logic ack);
    exp_t e;
    e.cyc = c;
    e.val = {ro, sd, ack};
    expq.push_back(e);
  endtask

  // t = edge on which RELEASE is entered
  task automatic push_seq(input int t, input logic ack);
    push(t + DLY,     3'b001, 1'b0, 1'b0);
    push(t + 2 * DLY, 3'b011, 1'b0, 1'b0);
    push(t + 3 * DLY, 3'b111, 1'b1, ack);
    if (ack) push(t + 3 * DLY + 1, 3'b111, 1'b1, 1'b0);
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (sif.soft_reset_ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", {31'd0, sif.soft_reset_ack}, 32'd1);
  endtask

  // Sub-cycle low pulse on reset_in_, placed between a negedge and the next posedge.
  task automatic async_pulse();
    #2 reset_in_ = 1'b0;
    #1 check("async_outputs", {sif.reset_out_, sif.seq_done, sif.soft_reset_ack}, 32'd0);
    check("async_lock_timeout", {31'd0, sif.lock_timeout}, 32'd0);
    #1 reset_in_ = 1'b1;
  endtask

  logic [4:0] prev = '0;

  always @(negedge clk) begin : monitor
    logic [4:0] cur;
    exp_t       e;
    cur = {sif.reset_out_, sif.seq_done, sif.soft_reset_ack};
    if (cur !== prev) begin
      prev = cur;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b exp=no_change", cyc, cur);
      end else begin
        e = expq.pop_front();
        check("change_cycle", cyc, e.cyc);
        check("change_value", {27'd0, cur}, {27'd0, e.val});
      end
    end
  end

  initial begin : stim
    int s;
    sif.soft_reset_req = 1'b0;
    #1 reset_in_ = 1'b0;
    goto(3);
    check("reset_out", {29'd0, sif.reset_out_}, 32'd0);
    check("reset_seq_done", {31'd0, sif.seq_done}, 32'd0);
    check("reset_ack", {31'd0, sif.soft_reset_ack}, 32'd0);
    check("reset_lock_timeout", {31'd0, sif.lock_timeout}, 32'd0);

    // power-on with lock already present
    s = cyc;
    reset_in_ = 1'b1;
    push_seq(s + 3, 1'b0);
    goto(s + 20);
    check("poweron_done", {31'd0, sif.seq_done}, 32'd1);

    // soft reset, request dropped on ack
    s = cyc;
    sif.soft_reset_req = 1'b1;
    push(s + 1, 3'b000, 1'b0, 1'b0);
    push_seq(s + 5, 1'b1);
    wait_ack();
    sif.soft_reset_req = 1'b0;
    goto(s + 25);

    // request held one cycle past ack starts a second sequence
    s = cyc;
    sif.soft_reset_req = 1'b1;
    push(s + 1, 3'b000, 1'b0, 1'b0);
    push_seq(s + 5, 1'b1);
    wait_ack();
    push(s + 19, 3'b000, 1'b0, 1'b0);
    push_seq(s + 23, 1'b1);
    @(negedge clk);
    @(negedge clk);
    sif.soft_reset_req = 1'b0;
    goto(s + 45);

    // lock loss at 001 during a soft sequence, then relock
    s = cyc;
    sif.soft_reset_req = 1'b1;
    push(s + 1, 3'b000, 1'b0, 1'b0);
    push(s + 9, 3'b001, 1'b0, 1'b0);
    goto(s + 9);
    pll_lock = 1'b0;
    push(s + 12, 3'b000, 1'b0, 1'b0);
    goto(s + 20);
    pll_lock = 1'b1;
    push_seq(s + 23, 1'b1);
    wait_ack();
    sif.soft_reset_req = 1'b0;
    goto(s + 45);

    // async reset glitch in RUN
    s = cyc;
    push(s + 1, 3'b000, 1'b0, 1'b0);
    push_seq(s + 3, 1'b0);
    async_pulse();
    goto(s + 20);

    // late lock, 50 cycles after reset release; watchdog window
    s = cyc;
    pll_lock = 1'b0;
    push(s + 1, 3'b000, 1'b0, 1'b0);
    async_pulse();
    goto(s + 33);
    check("wd_before_timeout", {31'd0, sif.lock_timeout}, 32'd0);
    goto(s + 34);
    check("wd_at_timeout", {31'd0, sif.lock_timeout}, {31'd0, WD_EXP});
    goto(s + 50);
    pll_lock = 1'b1;
    push_seq(s + 53, 1'b0);
    goto(s + 70);
    check("wd_sticky_after_lock", {31'd0, sif.lock_timeout}, {31'd0, WD_EXP});

    // reset clears the sticky flag and sequences again
    s = cyc;
    push(s + 1, 3'b000, 1'b0, 1'b0);
    push_seq(s + 3, 1'b0);
    async_pulse();
    goto(s + 20);
    check("final_done", {31'd0, sif.seq_done}, 32'd1);
    check("queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : guard
    #100000;
    $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
